// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Variable-latency memory responder with a valid/ready request and
//             response handshake and byte-masked writes.
//  Options  : MEM_ALIGN_CHECK_EN enables byte-enable legality checking.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int c_depth = 2 ** (ADDR_W - 2);
   localparam int c_cnt_w = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES);
   localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [c_cnt_w-1:0]  cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-3:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [31:0]         mem_q [c_depth];
   logic                w_legal;
   logic                w_mem_we;
   logic                unused_addr;

   assign unused_addr = ^{req_addr[31:ADDR_W], req_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      case (be_q)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: w_legal = 1'b1;
         default:                   w_legal = 1'b0;
      endcase
   end
`else
   assign w_legal = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // A zero wait still spends one cycle in WAIT, so response latency is
   // uniformly WAIT_CYCLES+1 edges after the accepting edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               idx_d   = req_addr[ADDR_W-1:2];
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = c_wait_load;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               rdata_d = (write_q || !w_legal) ? 32'd0 : mem_q[idx_q];
               err_d   = !w_legal;
            end else begin
               cnt_d = cnt_q - c_one;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Writes commit only on the WAIT->RESP edge; the array is never reset.
   assign w_mem_we = (state_q == S_WAIT) && (cnt_q == '0) && write_q && w_legal;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
`default_nettype wire
